// File: rtl/calc_pkg.sv
// Shared calculator definitions: BCD digit geometry, the clamp limit for the
// core's 16-bit operand path, and the converter state encoding.
package calc_pkg;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
  localparam logic [15:0] CLAMP_MAX     = 16'hFFFF;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } conv_state_t;

endpackage

// File: rtl/bcd_mac10.sv
// bcd_mac10: combinational multiply-by-10-and-add-digit step.
//   acc    [W-1:0]  running binary accumulator
//   digit  [3:0]    next BCD digit (assumed already validated)
//   result [W+3:0]  acc*10 + digit, wide enough that it never wraps
module bcd_mac10
  import calc_pkg::*;
#(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0]           acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [W+3:0]           result
);

  logic [W+3:0] acc_ext;

  always_comb begin
    acc_ext = (W+4)'(acc);
    // x*10 = x*8 + x*2
    result  = (acc_ext << 3) + (acc_ext << 1) + (W+4)'(digit);
  end

endmodule

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential packed-BCD to binary converter, one digit per
// clock, most-significant digit first.
//   clk, reset_n   clock (rising edge), asynchronous active-low reset
//   start          request, sampled only in IDLE
//   bcd_input      DIGITS packed BCD digits, digit DIGITS-1 at the MSBs
//   binary_output  result, held until the next accepted start
//   busy           high while converting
//   done           one-cycle pulse when binary_output/error are valid
//   error          input had a nibble > 9 (held with the result)
//   overflow       result was clamped to 16'hFFFF
// Optional build macro BCD2BIN_CLAMP_EN: clamp results above 65535 and
// report overflow; otherwise overflow is tied low.
module bcd_to_binary
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 5,
  parameter int unsigned BIN_W  = 17
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_input,
  output logic [BIN_W-1:0]              binary_output,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          overflow
);

  localparam int unsigned    IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  conv_state_t                   state_q, state_d;
  logic [BCD_DIGIT_W*DIGITS-1:0] shadow_q, shadow_d;
  logic [BIN_W-1:0]              acc_q, acc_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [BIN_W-1:0]              bin_q, bin_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          error_q, error_d;
  logic                          in_valid;
  logic [BCD_DIGIT_W-1:0]        cur_digit;
  logic [BIN_W+3:0]              mac_wide;
  logic                          unused_mac_hi;

  assign cur_digit = shadow_q[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W];

  bcd_mac10 #(.W(BIN_W)) u_mac (
    .acc    (acc_q),
    .digit  (cur_digit),
    .result (mac_wide)
  );

  // The width constraint on BIN_W guarantees these bits are zero.
  assign unused_mac_hi = ^mac_wide[BIN_W+3:BIN_W];

  always_comb begin
    in_valid = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_input[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) in_valid = 1'b0;
    end
  end

`ifdef BCD2BIN_CLAMP_EN
  logic overflow_q, overflow_d;
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    bin_d    = bin_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
`ifdef BCD2BIN_CLAMP_EN
    overflow_d = overflow_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = bcd_input;
          if (!in_valid) begin
            done_d  = 1'b1;
            error_d = 1'b1;
            bin_d   = '0;
`ifdef BCD2BIN_CLAMP_EN
            overflow_d = 1'b0;
`endif
          end else begin
            state_d = CONVERT;
            busy_d  = 1'b1;
            acc_d   = '0;
            idx_d   = LAST_IDX;
            error_d = 1'b0;
          end
        end
      end
      CONVERT: begin
        acc_d = mac_wide[BIN_W-1:0];
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef BCD2BIN_CLAMP_EN
          if (mac_wide > (BIN_W+4)'(CLAMP_MAX)) begin
            bin_d      = BIN_W'(CLAMP_MAX);
            overflow_d = 1'b1;
          end else begin
            bin_d      = mac_wide[BIN_W-1:0];
            overflow_d = 1'b0;
          end
`else
          bin_d = mac_wide[BIN_W-1:0];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      bin_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef BCD2BIN_CLAMP_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      bin_q    <= bin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
`ifdef BCD2BIN_CLAMP_EN
      overflow_q <= overflow_d;
`endif
    end
  end

  assign binary_output = bin_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [19:0] bcd_input;
  logic [16:0] binary_output;
  logic        busy, done, error, overflow;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  bcd_to_binary #(.DIGITS(5), .BIN_W(17)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .bcd_input     (bcd_input),
    .binary_output (binary_output),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .overflow      (overflow)
  );

  typedef struct {
    logic [19:0] bcd;
    int unsigned raw;   // decimal value before any clamping
    logic        err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply the output rules to a decimal value.
  function automatic void shape(input int unsigned raw, input logic err,
                                output logic [16:0] v, output logic o);
    o = 1'b0;
    if (err) v = '0;
    else begin
`ifdef BCD2BIN_CLAMP_EN
      if (raw > 65535) begin v = 17'h0FFFF; o = 1'b1; end
      else v = 17'(raw);
`else
      v = 17'(raw);
`endif
    end
  endfunction

  // Reference: weight each nibble by its power of ten.
  function automatic void model(input logic [19:0] b, output int unsigned raw, output logic err);
    int unsigned p;
    logic [19:0] t;
    raw = 0; p = 1; err = 1'b0; t = b;
    for (int i = 0; i < 5; i++) begin
      if (t[3:0] > 4'd9) err = 1'b1;
      raw += int'(t[3:0]) * p;
      p *= 10;
      t = t >> 4;
    end
  endfunction

  // From the current negedge, step one cycle at a time until done is seen.
  task automatic wait_done(output logic [16:0] bin, output logic e, output logic o,
                           output int lat, output int busy_n, output bit ok);
    lat = -1; busy_n = 0; ok = 1'b0; bin = '0; e = 1'b0; o = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (busy) busy_n++;
      if (done) begin
        ok = 1'b1; lat = k; bin = binary_output; e = error; o = overflow;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic launch(input logic [19:0] b);
    @(negedge clk);
    start = 1'b1; bcd_input = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [19:0] b,
                               input int unsigned raw, input logic err);
    logic [16:0] bin, ev;
    logic e, o, eo;
    int lat, bn;
    bit ok;
    shape(raw, err, ev, eo);
    launch(b);
    wait_done(bin, e, o, lat, bn, ok);
    check({tag, " done_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, " value"},    32'(bin), 32'(ev));
      check({tag, " error"},    32'(e),   32'(err));
      check({tag, " overflow"}, 32'(o),   32'(eo));
      check({tag, " latency"},  32'(lat), err ? 32'd0 : 32'd5);
      check({tag, " busy_cyc"}, 32'(bn),  err ? 32'd0 : 32'd5);
      @(negedge clk);
      check({tag, " done_pulse"}, 32'(done), 32'd0);
      check({tag, " held"}, 32'(binary_output), 32'(ev));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    logic [16:0] bin;
    logic e, o;
    int lat, bn, dcount;
    bit ok;
    logic [19:0] rb;
    int unsigned rraw;
    logic rerr;

    tbl[0] = '{20'h00000, 0,     1'b0};
    tbl[1] = '{20'h65535, 65535, 1'b0};
    tbl[2] = '{20'h99999, 99999, 1'b0};
    tbl[3] = '{20'h1A000, 0,     1'b1};
    tbl[4] = '{20'h00042, 42,    1'b0};
    tbl[5] = '{20'h12345, 12345, 1'b0};
    tbl[6] = '{20'h0000F, 0,     1'b1};
    tbl[7] = '{20'h00001, 1,     1'b0};
    tbl[8] = '{20'h10000, 10000, 1'b0};
    tbl[9] = '{20'h65536, 65536, 1'b0};

    reset_n = 1'b0; start = 1'b0; bcd_input = '0;
    repeat (2) @(negedge clk);
    check("reset bin", 32'(binary_output), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset error", 32'(error), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_and_check($sformatf("tbl%0d", i), tbl[i].bcd, tbl[i].raw, tbl[i].err);

    // Start while busy is ignored; start on the done cycle is accepted.
    launch(20'h12345);                       // E0 done, now after E1's negedge? no: after E0
    @(negedge clk);                          // after E1
    start = 1'b1; bcd_input = 20'h99999;     // sampled at E2
    @(negedge clk);
    start = 1'b0;
    wait_done(bin, e, o, lat, bn, ok);
    check("ignore done_seen", 32'(ok), 32'd1);
    check("ignore value", 32'(bin), 32'h03039);
    check("ignore latency", 32'(lat), 32'd3);
    start = 1'b1; bcd_input = 20'h00042;     // on the done cycle
    @(negedge clk);
    start = 1'b0;
    wait_done(bin, e, o, lat, bn, ok);
    check("ondone done_seen", 32'(ok), 32'd1);
    check("ondone value", 32'(bin), 32'h0002A);
    check("ondone latency", 32'(lat), 32'd5);

    // Reset mid-conversion.
    launch(20'h54321);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst bin", 32'(binary_output), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst error", 32'(error), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("midrst no_done", 32'(dcount), 32'd0);
    run_and_check("after_rst", 20'h54321, 54321, 1'b0);

    // Randomized against the reference model.
    for (int i = 0; i < 40; i++) begin
      rb = '0;
      for (int d = 0; d < 5; d++) begin
        rb = rb << 4;
        if ($urandom_range(0, 19) == 0) rb[3:0] = 4'($urandom_range(10, 15));
        else rb[3:0] = 4'($urandom_range(0, 9));
      end
      model(rb, rraw, rerr);
      run_and_check($sformatf("rnd%0d_%05h", i, rb), rb, rraw, rerr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
